cobs_encoder: RTL and testbench

Byte-stream COBS framer between the XADC sample packetizer and the FT232H USB FIFO sink. It takes raw packet bytes framed by tlast and re-encodes each packet with Consistent Overhead Byte Stuffing, so the payload contains no 0x00. Each packet is terminated with a single 0x00 delimiter, which lets the host resynchronise on any byte boundary.

---
 rtl/cobs_encoder_pkg.sv | 9 +
 rtl/cobs_block_buffer.sv | 21 ++
 rtl/cobs_encoder.sv | 152 +++++++++++++++
 tb/tb_cobs_encoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cobs_encoder_pkg.sv
// Shared COBS constants and encoder state type.
package cobs_package;

    localparam logic [7:0] COBS_DELIMITER = 8'h00;
    localparam int         COBS_MAX_BLOCK = 254;

    typedef enum logic [1:0] {FILL, EMIT_CODE, EMIT_DATA, EMIT_DELIM} cobs_encoder_state_t;

endpackage

// File: rtl/cobs_block_buffer.sv
// Holds the non-zero bytes of one COBS block; write on clock, read combinationally.
module cobs_block_buffer
    import cobs_package::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [COBS_MAX_BLOCK];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cobs_encoder.sv
// COBS framer: buffers one block of non-zero bytes, then emits code, data and
// (at packet end) an optional 0x01 tail block plus the 0x00 delimiter.
module cobs_encoder
    import cobs_package::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] raw_tdata,
    input  logic       raw_tvalid,
    output logic       raw_tready,
    input  logic       raw_tlast,
    output logic [7:0] cobs_tdata,
    output logic       cobs_tvalid,
    input  logic       cobs_tready,
    output logic       cobs_tlast
);

    cobs_encoder_state_t state, state_n;
    logic [7:0] count, count_n, count_inc;
    logic [7:0] rd_idx, rd_idx_n;
    logic       pending_tail, pending_tail_n;
    logic       eop, eop_n;
    logic       ready_en;
    logic [7:0] tdata_n;
    logic       tvalid_n, tlast_n;
    logic       buf_we, tail;
    logic       accept, nonzero, out_hs;
    logic [7:0] rd_data;

    cobs_block_buffer u_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_addr (count),
        .wr_data (raw_tdata),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // ready_en holds tready low during reset and until the first clock after it
    assign raw_tready = ready_en && (state == FILL);
    assign accept     = raw_tvalid && raw_tready;
    assign nonzero    = (raw_tdata != COBS_DELIMITER);
    assign out_hs     = cobs_tvalid && cobs_tready;
    assign count_inc  = count + {7'd0, nonzero};

    always_comb begin
        state_n        = state;
        count_n        = count;
        rd_idx_n       = rd_idx;
        pending_tail_n = pending_tail;
        eop_n          = eop;
        tdata_n        = cobs_tdata;
        tvalid_n       = cobs_tvalid;
        tlast_n        = cobs_tlast;
        buf_we         = 1'b0;
        tail           = 1'b0;

        case (state)
            FILL: begin
                if (accept) begin
                    buf_we  = nonzero;
                    count_n = count_inc;
                    if (!nonzero || count_inc == 8'(COBS_MAX_BLOCK) || raw_tlast) begin
                        // count_inc+1 is 0xFF exactly on the full-run close
                        state_n        = EMIT_CODE;
                        tdata_n        = count_inc + 8'd1;
                        tvalid_n       = 1'b1;
                        pending_tail_n = raw_tlast && !nonzero;
                        eop_n          = raw_tlast;
                    end
                end
            end
            EMIT_CODE: begin
                if (out_hs) begin
                    if (count != 8'd0) begin
                        state_n  = EMIT_DATA;
                        tdata_n  = rd_data;
                        rd_idx_n = rd_idx + 8'd1;
                    end else begin
                        tail = 1'b1;
                    end
                end
            end
            EMIT_DATA: begin
                // rd_idx points at the next byte to load into the output register
                if (out_hs) begin
                    if (rd_idx == count) begin
                        tail = 1'b1;
                    end else begin
                        tdata_n  = rd_data;
                        rd_idx_n = rd_idx + 8'd1;
                    end
                end
            end
            EMIT_DELIM: begin
                if (out_hs) begin
                    state_n        = FILL;
                    tvalid_n       = 1'b0;
                    tlast_n        = 1'b0;
                    tdata_n        = COBS_DELIMITER;
                    count_n        = 8'd0;
                    rd_idx_n       = 8'd0;
                    eop_n          = 1'b0;
                    pending_tail_n = 1'b0;
                end
            end
        endcase

        if (tail) begin
            count_n  = 8'd0;
            rd_idx_n = 8'd0;
            if (!eop) begin
                state_n  = FILL;
                tvalid_n = 1'b0;
                tdata_n  = COBS_DELIMITER;
            end else if (pending_tail) begin
                state_n        = EMIT_CODE;
                tdata_n        = 8'h01;
                pending_tail_n = 1'b0;
            end else begin
                state_n = EMIT_DELIM;
                tdata_n = COBS_DELIMITER;
                tlast_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FILL;
            count        <= 8'd0;
            rd_idx       <= 8'd0;
            pending_tail <= 1'b0;
            eop          <= 1'b0;
            ready_en     <= 1'b0;
            cobs_tdata   <= COBS_DELIMITER;
            cobs_tvalid  <= 1'b0;
            cobs_tlast   <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            rd_idx       <= rd_idx_n;
            pending_tail <= pending_tail_n;
            eop          <= eop_n;
            ready_en     <= 1'b1;
            cobs_tdata   <= tdata_n;
            cobs_tvalid  <= tvalid_n;
            cobs_tlast   <= tlast_n;
        end
    end

endmodule

// File: tb/tb_cobs_encoder.sv
// Scoreboard bench: packets are encoded by a segment-based COBS model into an
// expected queue; a monitor pops and compares on every output handshake.
module tb_cobs_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw_tdata;
    logic       raw_tvalid;
    logic       raw_tready;
    logic       raw_tlast;
    logic [7:0] cobs_tdata;
    logic       cobs_tvalid;
    logic       cobs_tready;
    logic       cobs_tlast;

    cobs_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .raw_tdata   (raw_tdata),
        .raw_tvalid  (raw_tvalid),
        .raw_tready  (raw_tready),
        .raw_tlast   (raw_tlast),
        .cobs_tdata  (cobs_tdata),
        .cobs_tvalid (cobs_tvalid),
        .cobs_tready (cobs_tready),
        .cobs_tlast  (cobs_tlast)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         outs  = 0;
    bit         bp_en = 1'b0;
    bit         abort = 1'b0;
    logic [8:0] expq[$];
    logic [7:0] pkt[$];

    // Reference: split the packet at zeros; each segment becomes 0xFF chunks
    // of 254 followed by a (len+1) block. The final segment needs no closing
    // block when it ends on an exact 254-byte chunk.
    task automatic push_chunk(input logic [7:0] code, input int p, input int len);
        expq.push_back({1'b0, code});
        for (int k = 0; k < len; k++) expq.push_back({1'b0, pkt[p+k]});
    endtask

    task automatic model_segment(input int s, input int len, input bit last);
        int p = s;
        int rem = len;
        while (rem > 254 || (!last && rem == 254)) begin
            push_chunk(8'hFF, p, 254);
            p += 254;
            rem -= 254;
        end
        if (last && rem == 254) push_chunk(8'hFF, p, 254);
        else                    push_chunk(8'(rem + 1), p, rem);
    endtask

    task automatic model_packet();
        int seg = 0;
        int n = pkt.size();
        for (int i = 0; i <= n; i++) begin
            if (i == n || pkt[i] == 8'h00) begin
                model_segment(seg, i - seg, i == n);
                seg = i + 1;
            end
        end
        expq.push_back({1'b1, 8'h00});
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int guard = 0;
        if (abort) return;
        raw_tdata  = d;
        raw_tlast  = last;
        raw_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (raw_tready) break;
            guard++;
            if (guard > 5000) begin
                tests++; fails++; abort = 1'b1;
                $display("FAIL input_timeout: tready stayed %b, required 1", raw_tready);
                raw_tvalid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        raw_tvalid = 1'b0;
        raw_tlast  = 1'b0;
    endtask

    task automatic send_packet(input bit gaps);
        model_packet();
        for (int i = 0; i < pkt.size(); i++) begin
            send_byte(pkt[i], i == pkt.size() - 1);
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (expq.size() != 0 && g < 20000) begin
            @(negedge clk);
            g++;
        end
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain_%s: %0d bytes outstanding, required 0", name, expq.size());
            expq.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        cobs_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [7:0] prev_d;
    logic       prev_l, prev_v, prev_r;
    logic [8:0] exp_b;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                tests++;
                if (cobs_tvalid !== 1'b1 || cobs_tdata !== prev_d || cobs_tlast !== prev_l) begin
                    fails++;
                    $display("FAIL hold_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                             cobs_tvalid, cobs_tdata, cobs_tlast, prev_d, prev_l);
                end
            end
            if (cobs_tvalid) begin
                tests++;
                if (raw_tready !== 1'b0) begin
                    fails++;
                    $display("FAIL ready_while_emitting: raw_tready=%b, required 0", raw_tready);
                end
            end
            if (cobs_tvalid && cobs_tready) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got %h/%b, required no output", cobs_tdata, cobs_tlast);
                end else begin
                    exp_b = expq.pop_front();
                    if ({cobs_tlast, cobs_tdata} !== exp_b) begin
                        fails++;
                        $display("FAIL out_byte[%0d]: got %h last=%b, required %h last=%b",
                                 outs, cobs_tdata, cobs_tlast, exp_b[7:0], exp_b[8]);
                    end
                end
                outs++;
            end
            prev_v = cobs_tvalid;
            prev_r = cobs_tready;
            prev_d = cobs_tdata;
            prev_l = cobs_tlast;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    initial begin
        int target, g, len, dens;
        rst = 1'b1;
        raw_tdata = 8'h00; raw_tvalid = 1'b0; raw_tlast = 1'b0;
        cobs_tready = 1'b1;
        #1;
        check("rst_tvalid", {31'd0, cobs_tvalid}, 0);
        check("rst_tlast",  {31'd0, cobs_tlast}, 0);
        check("rst_tdata",  {24'd0, cobs_tdata}, 0);
        check("rst_tready", {31'd0, raw_tready}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("tready_before_clock", {31'd0, raw_tready}, 0);
        @(posedge clk); #1;
        check("tready_after_clock", {31'd0, raw_tready}, 1);

        pkt = '{8'h11, 8'h22, 8'h00, 8'h33};
        send_packet(1'b0); drain("case1");
        pkt = '{8'h00};
        send_packet(1'b0); drain("single_zero");
        pkt.delete(); for (int i = 1; i <= 254; i++) pkt.push_back(8'(i));
        send_packet(1'b0); drain("run254");
        pkt.delete(); for (int i = 1; i <= 255; i++) pkt.push_back(8'(i));
        send_packet(1'b0); drain("run255");
        bp_en = 1'b1;
        pkt = '{8'h11, 8'h22, 8'h00, 8'h33};
        send_packet(1'b0); drain("case1_bp");
        pkt.delete(); for (int i = 0; i < 254; i++) pkt.push_back(8'(i + 1)); pkt.push_back(8'h00);
        send_packet(1'b0); drain("run254_zero");

        for (int n = 0; n < 40; n++) begin
            len  = (n % 5 == 4) ? int'($urandom_range(250, 520)) : int'($urandom_range(1, 20));
            dens = $urandom_range(0, 2);
            pkt.delete();
            for (int i = 0; i < len; i++) begin
                if (dens != 0 && $urandom_range(0, (dens == 1) ? 9 : 1) == 0) pkt.push_back(8'h00);
                else pkt.push_back(8'($urandom_range(1, 255)));
            end
            bp_en = 1'($urandom_range(0, 1));
            send_packet(1'b1);
            drain("random");
        end

        bp_en = 1'b0;
        pkt.delete(); for (int i = 1; i <= 254; i++) pkt.push_back(8'(i));
        target = outs + 10;
        send_packet(1'b0);
        g = 0;
        while (outs < target && g < 2000) begin @(negedge clk); g++; end
        check("reset_reached_10", {31'd0, outs >= target}, 1);
        #2 rst = 1'b1;
        #1;
        check("async_tvalid_drop", {31'd0, cobs_tvalid}, 0);
        check("async_tready_drop", {31'd0, raw_tready}, 0);
        expq.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        pkt = '{8'h05};
        send_packet(1'b0); drain("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
